// File: rtl/bcd_display_scanner_pkg.sv
// Shared encodings for the two-digit BCD display scanner.
package bcd_disp_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW0 = 2'd1,
    SHOW1 = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;
  localparam logic [1:0] SEL_OFF  = 2'b00;
endpackage

// File: rtl/bcd_display_scanner_decoderBCD.sv
// Binary 0..31 to BCD ones/tens digit decoder.
module decoderBCD (
  input  logic [4:0] in,
  output logic [3:0] out0,
  output logic [3:0] out1
);
  always_comb begin
    out0 = 4'(in % 5'd10);
    out1 = 4'(in / 5'd10);
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit time-multiplexed BCD display scanner with valid/ready intake.
// Optional BLANK_LEADING_ZERO_EN darkens the tens slot when the tens digit is 0.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  input  logic       clear,
  output logic [3:0] digit,
  output logic [1:0] digit_sel,
  output logic       frame_done
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(SCAN_DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    val_q, val_d;
  logic [3:0]    digit_q;
  logic [1:0]    sel_q;
  logic [3:0]    ones, tens;
  logic          tc, xfer;

  assign tc         = (state_q != IDLE) && (cnt_q == TC_VAL);
  assign in_ready   = !clear && ((state_q == IDLE) || tc);
  assign xfer       = in_valid && in_ready;
  assign frame_done = (state_q == SHOW1) && tc && !clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (xfer) begin
      state_d = SHOW0;
      cnt_d   = '0;
      val_d   = in_data;
    end else if (state_q != IDLE) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
      if (tc) state_d = (state_q == SHOW0) ? SHOW1 : SHOW0;
    end
  end

  // Decoding the next held value lets the digit register load the new
  // ones digit on the transfer edge, giving one cycle of latency.
  decoderBCD u_dec (
    .in   (val_d),
    .out0 (ones),
    .out1 (tens)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      digit_q <= '0;
      sel_q   <= SEL_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      case (state_d)
        SHOW0: begin
          digit_q <= ones;
          sel_q   <= SEL_ONES;
        end
        SHOW1: begin
`ifdef BLANK_LEADING_ZERO_EN
          if (tens == 4'd0) begin
            digit_q <= '0;
            sel_q   <= SEL_OFF;
          end else begin
            digit_q <= tens;
            sel_q   <= SEL_TENS;
          end
`else
          digit_q <= tens;
          sel_q   <= SEL_TENS;
`endif
        end
        default: begin
          digit_q <= '0;
          sel_q   <= SEL_OFF;
        end
      endcase
    end
  end

  assign digit     = digit_q;
  assign digit_sel = sel_q;
endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed two-digit BCD display controller. Accepts a 5-bit binary value over a valid/ready handshake, converts it with the team's `decoderBCD` block, and scans the ones and tens digits onto a shared 4-bit digit bus with a one-hot digit select. It sits between the value producer and the 7-segment driver, and is the sole sequencer of the decoder.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per digit slot; legal range 2..65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: producer has a value on `in_data`.
- `in_data` in 5: binary value 0..31.
- `in_ready` out 1: controller accepts `in_data` this cycle.
- `clear` in 1: synchronous return to blank/IDLE.
- `digit` out 4: BCD digit for the active slot.
- `digit_sel` out 2: one-hot select; bit0 = ones, bit1 = tens, 00 = dark.
- `frame_done` out 1: one-cycle pulse at the end of each tens slot.

## Operation
- States: IDLE, SHOW0 (ones slot), SHOW1 (tens slot).
- Held register `val[4:0]` feeds `decoderBCD`. The decoder gives ones 0..9 and tens 0..3.
- Prescaler `cnt` counts 0..SCAN_DIV-1 in SHOW0/SHOW1. Terminal count (TC) is `cnt == SCAN_DIV-1`. `cnt` wraps to 0 at TC.
- Handshake rule:
  - `in_ready` is 1 in IDLE.
  - `in_ready` is 1 in SHOW0/SHOW1 only on the TC cycle.
  - `in_ready` is 0 whenever `clear` is 1.
  - A transfer occurs on `in_valid && in_ready`.
- Transitions:
  - IDLE + transfer → SHOW0; `cnt` ← 0.
  - SHOW0 at TC → SHOW1.
  - SHOW1 at TC → SHOW0, with `frame_done` = 1 on that TC cycle.
  - Any TC with a transfer → SHOW0 and `val` updated, regardless of current slot.
  - `clear` = 1 → IDLE next cycle from any state. `clear` overrides `in_valid`.
- Outputs are registered:
  - In IDLE: `digit` = 0, `digit_sel` = 00.
  - In SHOW0: `digit` = ones(`val`), `digit_sel` = 01.
  - In SHOW1: `digit` = tens(`val`), `digit_sel` = 10.
- `in_data` values are always in range (5 bits); no saturation is needed.

## Timing
- Reset: state IDLE, `val` = 0, `cnt` = 0, `digit` = 0, `digit_sel` = 00, `in_ready` = 1, `frame_done` = 0. Takes effect immediately on `rst_n` falling, including mid-slot.
- Latency from a transfer to the new ones digit on `digit`/`digit_sel`: 1 cycle.
- Each slot lasts exactly SCAN_DIV cycles. One frame is 2·SCAN_DIV cycles.
- `in_ready` is combinational from state/`cnt`/`clear`. It does not depend on `in_valid`.
- The displayed value never changes mid-slot. New data appears only at a slot boundary or when leaving IDLE.
- If `clear` and TC occur in the same cycle, there is no transfer and no `frame_done`; next state is IDLE.

## Configuration
- `BLANK_LEADING_ZERO_EN` defined: in SHOW1, when tens(`val`) = 0, `digit_sel` = 00 and `digit` = 0. Slot timing and `frame_done` are unchanged.
- Not defined: a tens digit of 0 is displayed normally (`digit_sel` = 10, `digit` = 0).

## Structure
- Package `bcd_disp_pkg`: state encoding (IDLE = 2'd0, SHOW0 = 2'd1, SHOW1 = 2'd2), `SEL_ONES` = 2'b01, `SEL_TENS` = 2'b10, `SEL_OFF` = 2'b00.
- One sub-module: `decoderBCD`, instantiated unchanged, in = `val`, out0 = ones, out1 = tens.
- The prescaler and FSM live in this module. `cnt` width is $clog2(SCAN_DIV).

## Test plan
All scenarios use SCAN_DIV = 4.
- Reset, then idle 10 cycles → `digit_sel` = 00, `digit` = 0, `in_ready` = 1, `frame_done` never pulses.
- Transfer 23 from IDLE → next cycle `digit` = 3 / `digit_sel` = 01 for 4 cycles, then `digit` = 2 / `digit_sel` = 10 for 4 cycles; `frame_done` pulses once per 8 cycles.
- Hold `in_valid` = 1 with 17 while showing 23 → `in_ready` high only on TC cycles; transfer at the next TC; following cycle `digit` = 7 / `digit_sel` = 01.
- Transfer 5 → tens slot shows `digit_sel` = 00 with `BLANK_LEADING_ZERO_EN`, and `digit_sel` = 10 / `digit` = 0 without it.
- Sweep 0..31, one transfer per frame → (tens, ones) matches value/10 and value%10 for every value, including 31 → 3, 1.
- Assert `clear` mid-slot, and separately on a TC cycle with `in_valid` = 1 → IDLE next cycle, no transfer, no `frame_done`. Drop `rst_n` mid-slot → all outputs reset asynchronously.
